wb_queue: RTL and testbench

Writeback queue sitting directly upstream of the 32 x 32 register bank. It accepts results from two producers (ALU and memory unit) over valid/ready handshakes, buffers them in a small in-order FIFO, and drains one entry per cycle into the bank's single write port (`write`, `dr`, `wrData`). It also provides forwarding lookups on both read addresses so operand fetch sees queued results before they commit to the bank.

---
 rtl/wb_queue.sv | 113 +++++++++++
 tb/tb_wb_queue.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU/memory results in order, drains one entry per
// cycle into the register bank write port, and forwards queued data to reads.
//
// Ports:
//   clk, reset (async, active-low)
//   mem_valid/mem_ready/mem_dr/mem_data : memory result handshake
//   alu_valid/alu_ready/alu_dr/alu_data : ALU result handshake
//   write/dr/wrData                     : register bank write port
//   sr1/sr2 -> fwd1_hit/fwd1_data, fwd2_hit/fwd2_data : forwarding lookups
//   count                               : occupied entries (0..DEPTH)
module wb_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mem_valid,
    output logic                     mem_ready,
    input  logic [4:0]               mem_dr,
    input  logic [31:0]              mem_data,
    input  logic                     alu_valid,
    output logic                     alu_ready,
    input  logic [4:0]               alu_dr,
    input  logic [31:0]              alu_data,
    output logic                     write,
    output logic [4:0]               dr,
    output logic [31:0]              wrData,
    input  logic [4:0]               sr1,
    input  logic [4:0]               sr2,
    output logic                     fwd1_hit,
    output logic [31:0]              fwd1_data,
    output logic                     fwd2_hit,
    output logic [31:0]              fwd2_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [4:0]    q_dr   [DEPTH];
    logic [31:0]   q_data [DEPTH];
    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [CW-1:0] free;
    logic          mem_acc;
    logic          alu_acc;
    logic [AW-1:0] alu_slot;
    logic [1:0]    n_acc;

    // Free space ignores the entry draining this cycle, so readies depend
    // only on registered state.
    assign free      = CW'(DEPTH) - count;
    assign mem_ready = (free >= CW'(1));
    assign alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));

    assign mem_acc  = mem_valid & mem_ready;
    assign alu_acc  = alu_valid & alu_ready;
    assign n_acc    = {1'b0, mem_acc} + {1'b0, alu_acc};
    // Memory result is older when both arrive together.
    assign alu_slot = mem_acc ? tail + AW'(1) : tail;

    assign write  = (count != '0);
    assign dr     = write ? q_dr[head]   : 5'd0;
    assign wrData = write ? q_data[head] : 32'd0;

    // Scan oldest to youngest so the last match wins.
    always_comb begin
        logic [AW-1:0] idx;
        fwd1_hit  = 1'b0;
        fwd1_data = 32'd0;
        fwd2_hit  = 1'b0;
        fwd2_data = 32'd0;
        idx       = head;
        for (int i = 0; i < DEPTH; i++) begin
            idx = head + AW'(i);
            if (CW'(i) < count) begin
                if (q_dr[idx] == sr1) begin
                    fwd1_hit  = 1'b1;
                    fwd1_data = q_data[idx];
                end
                if (q_dr[idx] == sr2) begin
                    fwd2_hit  = 1'b1;
                    fwd2_data = q_data[idx];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                q_dr[i]   <= 5'd0;
                q_data[i] <= 32'd0;
            end
        end else begin
            if (mem_acc) begin
                q_dr[tail]   <= mem_dr;
                q_data[tail] <= mem_data;
            end
            if (alu_acc) begin
                q_dr[alu_slot]   <= alu_dr;
                q_data[alu_slot] <= alu_data;
            end
            tail <= tail + AW'(n_acc);
            if (write)
                head <= head + AW'(1);
            count <= count + CW'(n_acc) - CW'(write);
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: queue-based reference model compared
// every cycle, plus directed literal checks and randomized traffic.
module tb_wb_queue;

    localparam int DEPTH = 4;

    typedef struct packed {
        logic [4:0]  dr;
        logic [31:0] data;
    } ent_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid, alu_valid;
    logic        mem_ready, alu_ready;
    logic [4:0]  mem_dr, alu_dr;
    logic [31:0] mem_data, alu_data;
    logic        write;
    logic [4:0]  dr;
    logic [31:0] wrData;
    logic [4:0]  sr1, sr2;
    logic        fwd1_hit, fwd2_hit;
    logic [31:0] fwd1_data, fwd2_data;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;
    int naccepted = 0;

    ent_t        q[$];
    logic [31:0] ref_bank [32];
    logic [31:0] dut_bank [32];

    wb_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .mem_valid(mem_valid), .mem_ready(mem_ready),
        .mem_dr(mem_dr), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready),
        .alu_dr(alu_dr), .alu_data(alu_data),
        .write(write), .dr(dr), .wrData(wrData),
        .sr1(sr1), .sr2(sr2),
        .fwd1_hit(fwd1_hit), .fwd1_data(fwd1_data),
        .fwd2_hit(fwd2_hit), .fwd2_data(fwd2_data),
        .count(count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                     $time);
        end
    endtask

    task automatic fwd_model(input logic [4:0] sr, output logic hit,
                             output logic [31:0] data);
        hit  = 1'b0;
        data = 32'd0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (q[i].dr == sr) begin
                hit  = 1'b1;
                data = q[i].data;
                break;
            end
        end
    endtask

    task automatic check_outputs();
        int          n;
        logic        h;
        logic [31:0] d;
        n = q.size();
        chk("write", 32'(write), 32'(n != 0));
        chk("dr", 32'(dr), n != 0 ? 32'(q[0].dr) : 32'd0);
        chk("wrData", wrData, n != 0 ? q[0].data : 32'd0);
        chk("count", 32'(count), 32'(n));
        chk("mem_ready", 32'(mem_ready), 32'(DEPTH - n >= 1));
        chk("alu_ready", 32'(alu_ready),
            32'(mem_valid ? (DEPTH - n >= 2) : (DEPTH - n >= 1)));
        fwd_model(sr1, h, d);
        chk("fwd1_hit", 32'(fwd1_hit), 32'(h));
        chk("fwd1_data", fwd1_data, d);
        fwd_model(sr2, h, d);
        chk("fwd2_hit", 32'(fwd2_hit), 32'(h));
        chk("fwd2_data", fwd2_data, d);
    endtask

    task automatic cycle();
        int          n;
        bit          ma, aa;
        logic        s_w;
        logic [4:0]  s_dr;
        logic [31:0] s_wd;
        @(negedge clk);
        check_outputs();
        s_w  = write;
        s_dr = dr;
        s_wd = wrData;
        n    = q.size();
        ma   = mem_valid && (DEPTH - n >= 1);
        aa   = alu_valid && (mem_valid ? (DEPTH - n >= 2) : (DEPTH - n >= 1));
        @(posedge clk);
        if (reset) begin
            if (s_w)
                dut_bank[s_dr] = s_wd;
            if (n != 0) begin
                ref_bank[q[0].dr] = q[0].data;
                void'(q.pop_front());
            end
            if (ma) begin
                q.push_back({mem_dr, mem_data});
                naccepted++;
            end
            if (aa) begin
                q.push_back({alu_dr, alu_data});
                naccepted++;
            end
        end
        #1;
    endtask

    task automatic idle();
        mem_valid = 1'b0;
        alu_valid = 1'b0;
    endtask

    initial begin
        int cyc;
        int sent;
        bit side;
        for (int i = 0; i < 32; i++) begin
            ref_bank[i] = 32'd0;
            dut_bank[i] = 32'd0;
        end
        reset     = 1'b0;
        mem_valid = 1'b1;
        alu_valid = 1'b1;
        mem_dr    = 5'd9;
        mem_data  = 32'h1234;
        alu_dr    = 5'd8;
        alu_data  = 32'h5678;
        sr1       = 5'd9;
        sr2       = 5'd8;

        // Reset held with valids high
        repeat (3) cycle();
        chk("rst_write", 32'(write), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd1);
        chk("rst_alu_ready", 32'(alu_ready), 32'd1);

        reset = 1'b1;
        idle();
        cycle();

        // First enqueue after reset
        mem_valid = 1'b1;
        mem_dr    = 5'd3;
        mem_data  = 32'hDEADBEEF;
        sr1       = 5'd3;
        cycle();
        idle();
        chk("first_write", 32'(write), 32'd1);
        chk("first_dr", 32'(dr), 32'd3);
        chk("first_data", wrData, 32'hDEADBEEF);
        chk("first_fwd1_hit", 32'(fwd1_hit), 32'd1);
        cycle();
        chk("first_bank", dut_bank[3], 32'hDEADBEEF);

        // Dual enqueue, same destination
        mem_valid = 1'b1;
        alu_valid = 1'b1;
        mem_dr    = 5'd5;
        mem_data  = 32'h11;
        alu_dr    = 5'd5;
        alu_data  = 32'h22;
        sr1       = 5'd5;
        cycle();
        idle();
        chk("dual_count", 32'(count), 32'd2);
        chk("dual_wr0", wrData, 32'h11);
        chk("dual_fwd0", fwd1_data, 32'h22);
        cycle();
        chk("dual_wr1", wrData, 32'h22);
        chk("dual_fwd1", fwd1_data, 32'h22);
        chk("dual_hit1", 32'(fwd1_hit), 32'd1);
        cycle();
        chk("dual_hit2", 32'(fwd1_hit), 32'd0);
        chk("dual_fdat2", fwd1_data, 32'd0);
        chk("dual_bank", dut_bank[5], 32'h22);

        // Forwarding hit on one port, miss on the other
        mem_valid = 1'b1;
        alu_valid = 1'b1;
        mem_dr    = 5'd1;
        mem_data  = 32'hA;
        alu_dr    = 5'd2;
        alu_data  = 32'hB;
        sr1       = 5'd2;
        sr2       = 5'd7;
        cycle();
        idle();
        chk("fwd_hit1", 32'(fwd1_hit), 32'd1);
        chk("fwd_data1", fwd1_data, 32'hB);
        chk("fwd_hit2", 32'(fwd2_hit), 32'd0);
        chk("fwd_data2", fwd2_data, 32'd0);
        repeat (3) cycle();

        // Fill: dual issue every cycle, distinct destinations
        for (int i = 0; i < 12; i++) begin
            mem_valid = 1'b1;
            alu_valid = 1'b1;
            mem_dr    = 5'((2 * i) % 32);
            alu_dr    = 5'((2 * i + 1) % 32);
            mem_data  = $urandom;
            alu_data  = $urandom;
            cycle();
        end
        chk("fill_count", 32'(count), 32'(DEPTH - 1));
        chk("fill_alu_stall", 32'(alu_ready), 32'd0);
        chk("fill_mem_ready", 32'(mem_ready), 32'd1);
        idle();
        repeat (5) cycle();

        // Random traffic
        for (int i = 0; i < 150; i++) begin
            mem_valid = 1'($urandom_range(0, 1));
            alu_valid = 1'($urandom_range(0, 1));
            mem_dr    = 5'($urandom_range(0, 7));
            alu_dr    = 5'($urandom_range(0, 7));
            mem_data  = $urandom;
            alu_data  = $urandom;
            sr1       = 5'($urandom_range(0, 7));
            sr2       = 5'($urandom_range(0, 7));
            cycle();
        end
        idle();
        repeat (5) cycle();

        // Reset mid-operation with three entries queued
        mem_valid = 1'b1;
        alu_valid = 1'b1;
        mem_dr    = 5'd10;
        mem_data  = 32'hCAFE0010;
        alu_dr    = 5'd11;
        alu_data  = 32'hCAFE0011;
        cycle();
        mem_dr    = 5'd12;
        mem_data  = 32'hCAFE0012;
        alu_dr    = 5'd13;
        alu_data  = 32'hCAFE0013;
        cycle();
        idle();
        chk("mid_pre_count", 32'(count), 32'd3);
        reset = 1'b0;
        q.delete();
        #1;
        chk("mid_write", 32'(write), 32'd0);
        chk("mid_count", 32'(count), 32'd0);
        repeat (2) cycle();
        reset = 1'b1;
        repeat (3) cycle();

        // Wrap-around: single alternating enqueues at random rate
        sent = naccepted;
        side = 1'b0;
        cyc  = 0;
        while (naccepted - sent < 20 && cyc < 400) begin
            idle();
            if ($urandom_range(0, 1) == 1) begin
                if (side) begin
                    alu_valid = 1'b1;
                    alu_dr    = 5'($urandom_range(0, 31));
                    alu_data  = $urandom;
                end else begin
                    mem_valid = 1'b1;
                    mem_dr    = 5'($urandom_range(0, 31));
                    mem_data  = $urandom;
                end
                side = ~side;
            end
            sr1 = 5'($urandom_range(0, 31));
            sr2 = 5'($urandom_range(0, 31));
            cycle();
            cyc++;
        end
        chk("wrap_done", 32'(naccepted - sent >= 20), 32'd1);
        idle();
        repeat (6) cycle();

        for (int i = 0; i < 32; i++)
            chk($sformatf("bank%0d", i), dut_bank[i], ref_bank[i]);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
